mips_load_store_unit: RTL and testbench
=======================================

Name: mips_load_store_unit

Overview:
Multi-cycle load/store controller between the datapath's execute stage and the word-wide data memory. It accepts MIPS load/store requests with byte addresses and drives a word-addressed memory port with registered reads. Byte and halfword stores use read-modify-write. Load results are lane-extracted and sign- or zero-extended for write-back.

Parameters:
ADDR_W, 8, memory word-address width (memory depth = 2**ADDR_W words)

Ports:
clock  in  1  single system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present from datapath
req_ready  out  1  unit can accept a request this cycle
opcode  in  6  MIPS opcode: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sb 101000, sh 101001
addr  in  32  byte address
store_data  in  32  store operand; low byte/half used for sb/sh
resp_valid  out  1  one-cycle pulse: request complete
load_data  out  32  extended load result; valid when resp_valid is high
misaligned  out  1  qualifies resp_valid: request aborted on alignment
busy  out  1  high in every state except IDLE; datapath stall
mem_addr  out  ADDR_W  word index = addr[ADDR_W+1:2]
mem_re  out  1  read strobe; mem_rdata is valid the cycle after mem_re
mem_rdata  in  32  memory read word
mem_we  out  1  write strobe
mem_wdata  out  32  full word to write

Behaviour:
- Reset state: IDLE. Outputs on reset: req_ready=1, resp_valid=0, misaligned=0, load_data=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0. A reset in any state aborts the operation. An RMW aborted before WRITE performs no write.
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch opcode, addr and store_data.
- IDLE transitions after accept:
  - misaligned or unknown opcode -> RESP
  - sw -> WRITE
  - any load, sb or sh -> READ
- Alignment rules: lw/sw need addr[1:0]=0. lh/lhu/sh need addr[0]=0. Byte operations are always aligned.
- Misaligned request: no memory strobe is issued. RESP has misaligned=1 and load_data=0.
- Unknown opcode: no memory access. RESP has misaligned=0 and load_data=0.
- READ: mem_re=1 for one cycle -> WAIT.
- WAIT: capture mem_rdata.
  - load: extract lane -> RESP
  - sb/sh: build merged word -> WRITE
- WRITE: mem_we=1 for exactly one cycle with mem_wdata -> RESP.
- RESP: resp_valid=1 for one cycle -> IDLE. There is no backpressure. The next request can be accepted the cycle after RESP.
- Latency from the accept edge to the resp_valid cycle:
  - sw: 2
  - loads: 3
  - sb/sh: 4
  - misaligned or unknown: 1
- Byte lanes are little-endian:
  - byte offset k maps to bits [8k+7:8k]
  - halfword at offset 0 maps to [15:0], offset 2 maps to [31:16]
- Load extension: lb/lh sign-extend. lbu/lhu zero-extend. lw passes the word through.
- sb/sh merge: replace only the addressed lane with store_data[7:0] or [15:0]. Other lanes keep the value read in WAIT.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo memory size.
- mem_addr is held stable from READ through WRITE.
- req_valid while busy is ignored and not queued.

Decomposition:
- Package mips_lsu_pkg:
  - opcode constants (OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH)
  - state encoding
  - decode helpers: is_load, is_store, access size
- Sub-module mips_lane_align: combinational lane extract/extend for loads and lane merge for stores, with inputs word, offset, size and signedness.

Test Plan:
- Reset mid-RMW: sb accepted, reset asserted in WAIT -> mem_we never rises, next cycle req_ready=1 and all outputs are 0.
- sw addr=0x10, data=0xDEADBEEF -> mem_we=1 at mem_addr=4 with 0xDEADBEEF. resp_valid arrives 2 cycles after accept with misaligned=0.
- Memory word 4 = 0x80F17F02:
  - lb addr=0x13 -> load_data=0xFFFFFF80
  - lbu addr=0x13 -> 0x00000080
  - lh addr=0x10 -> 0x00007F02
  - lhu addr=0x12 -> 0x000080F1
  - each completes in 3 cycles
- Memory word 4 = 0x11223344:
  - sb addr=0x11, data=0xAA -> written 0x1122AA44
  - sh addr=0x12, data=0xBEEF -> written 0xBEEF3344
  - each resp_valid is 4 cycles after accept
- lw addr=0x06 and sh addr=0x03 -> resp_valid 1 cycle after accept, misaligned=1, load_data=0, no mem_re/mem_we pulse.
- Back-to-back: req_valid held high with a second request during busy -> second is accepted only the cycle after RESP. Addr 0x400 wraps to mem_addr=0 with ADDR_W=8.

Source files
------------

// File: rtl/mips_load_store_unit_pkg.sv
// rtl/mips_load_store_unit_pkg.sv - opcodes, state encoding and decode helpers for the load/store unit
package mips_lsu_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_LH) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_known(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Only lb and lh sign-extend; every other opcode passes or zero-fills
    function automatic logic is_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic size_t access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] offset);
        case (access_size(op))
            SZ_WORD: return offset == 2'b00;
            SZ_HALF: return offset[0] == 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mips_load_store_unit_if.sv
// rtl/mips_load_store_unit_if.sv - request/response and memory port bundle of the load/store unit
interface mips_lsu_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        opcode;
    logic [31:0]       addr;
    logic [31:0]       store_data;
    logic              resp_valid;
    logic [31:0]       load_data;
    logic              misaligned;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    // Environment side: datapath issuing requests plus the data memory
    modport master (
        output req_valid, opcode, addr, store_data, mem_rdata,
        input  req_ready, resp_valid, load_data, misaligned, busy,
               mem_addr, mem_re, mem_we, mem_wdata
    );

    // Load/store unit side
    modport slave (
        input  req_valid, opcode, addr, store_data, mem_rdata,
        output req_ready, resp_valid, load_data, misaligned, busy,
               mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/mips_load_store_unit_lane_align.sv
// rtl/mips_load_store_unit_lane_align.sv - little-endian lane extract/extend and lane merge
module mips_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it; build the read-modify-write word
    always_comb begin
        byte_sel   = word[7:0];
        half_sel   = offset[1] ? word[31:16] : word[15:0];
        load_value = word;
        merged     = word;

        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase

        case (size)
            SZ_BYTE: begin
                load_value = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                case (offset)
                    2'd0:    merged[7:0]   = store_data[7:0];
                    2'd1:    merged[15:8]  = store_data[7:0];
                    2'd2:    merged[23:16] = store_data[7:0];
                    default: merged[31:24] = store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                load_value = {{16{sign_ext & half_sel[15]}}, half_sel};
                if (offset[1]) merged[31:16] = store_data[15:0];
                else           merged[15:0]  = store_data[15:0];
            end
            default: begin
                load_value = word;
                merged     = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// rtl/mips_load_store_unit.sv - multi-cycle MIPS load/store controller with read-modify-write sub-word stores
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input logic       clock,
    input logic       reset,
    mips_lsu_if.slave bus
);

    state_t            state;
    state_t            state_next;
    logic [5:0]        op_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       result_q;
    logic              mis_q;
    logic [31:0]       load_value;
    logic [31:0]       merged;
    logic              accept_bad;
    logic              unused_addr_bits;

    // Byte address bits beyond the memory size are dropped so addresses wrap
    assign unused_addr_bits = &{1'b0, bus.addr[31:ADDR_W+2]};

    // Known opcode whose address violates its access size
    assign accept_bad = is_known(bus.opcode) && !is_aligned(bus.opcode, bus.addr[1:0]);

    mips_lane_align u_lane_align (
        .word       (bus.mem_rdata),
        .offset     (addr_q[1:0]),
        .size       (access_size(op_q)),
        .sign_ext   (is_signed(op_q)),
        .store_data (wdata_q),
        .load_value (load_value),
        .merged     (merged)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and strobes; a reset anywhere drops back to IDLE without writing
    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.busy       = 1'b1;
        bus.mem_re     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    if (!is_known(bus.opcode) || accept_bad) state_next = ST_RESP;
                    else if (bus.opcode == OP_SW)            state_next = ST_WRITE;
                    else                                     state_next = ST_READ;
                end
            end
            ST_READ: begin
                bus.mem_re = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                state_next = is_load(op_q) ? ST_RESP : ST_WRITE;
            end
            ST_WRITE: begin
                bus.mem_we = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch on accept; load result or merged store word captured in WAIT
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.req_valid) begin
                op_q     <= bus.opcode;
                addr_q   <= bus.addr[ADDR_W+1:0];
                wdata_q  <= bus.store_data;
                result_q <= '0;
                mis_q    <= accept_bad;
            end else if (state == ST_WAIT) begin
                if (is_load(op_q)) result_q <= load_value;
                else               wdata_q  <= merged;
            end
        end
    end

    assign bus.mem_addr   = addr_q[ADDR_W+1:2];
    assign bus.mem_wdata  = bus.mem_we ? wdata_q : 32'h0;
    assign bus.load_data  = bus.resp_valid ? result_q : 32'h0;
    assign bus.misaligned = bus.resp_valid & mis_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// tb/tb_mips_load_store_unit.sv - scoreboard bench for mips_load_store_unit
module tb_mips_load_store_unit;
    import mips_lsu_pkg::*;

    typedef struct {
        int          cyc;
        logic        mis;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   reads_seen = 0;
    int   exp_reads = 0;
    resp_t resp_q[$];
    wr_t   wr_q[$];
    resp_t r_exp;
    wr_t   w_exp;
    logic [31:0] mem [256];

    mips_lsu_if #(.ADDR_W(8)) bus ();

    mips_load_store_unit #(.ADDR_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Word memory with registered read
    always @(posedge clock) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected responses and writes whenever the DUT presents one
    always @(negedge clock) begin
        if (bus.mem_re) reads_seen++;
        if (bus.resp_valid) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'h1, 32'h0);
            end else begin
                r_exp = resp_q.pop_front();
                check("resp_cycle", cyc, r_exp.cyc);
                check("resp_misaligned", {31'h0, bus.misaligned}, {31'h0, r_exp.mis});
                check("resp_load_data", bus.load_data, r_exp.data);
            end
        end
        if (bus.mem_we) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'h1, 32'h0);
            end else begin
                w_exp = wr_q.pop_front();
                check("write_cycle", cyc, w_exp.cyc);
                check("write_addr", {24'h0, bus.mem_addr}, {24'h0, w_exp.addr});
                check("write_data", bus.mem_wdata, w_exp.data);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) check("req_ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic mis, input logic [31:0] ld,
                         input logic wr, input logic [7:0] waddr, input logic [31:0] wdata,
                         input int wlat, input logic rd);
        int ca;
        wait_ready();
        ca = cyc;
        resp_q.push_back(resp_t'{ca + lat, mis, ld});
        if (wr) wr_q.push_back(wr_t'{ca + wlat, waddr, wdata});
        if (rd) exp_reads++;
        bus.opcode     = op;
        bus.addr       = a;
        bus.store_data = d;
        bus.req_valid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"},  {31'h0, bus.req_ready},  32'h1);
        check({tag, "_busy"},       {31'h0, bus.busy},       32'h0);
        check({tag, "_resp_valid"}, {31'h0, bus.resp_valid}, 32'h0);
        check({tag, "_misaligned"}, {31'h0, bus.misaligned}, 32'h0);
        check({tag, "_load_data"},  bus.load_data,           32'h0);
        check({tag, "_mem_re"},     {31'h0, bus.mem_re},     32'h0);
        check({tag, "_mem_we"},     {31'h0, bus.mem_we},     32'h0);
        check({tag, "_mem_addr"},   {24'h0, bus.mem_addr},   32'h0);
        check({tag, "_mem_wdata"},  bus.mem_wdata,           32'h0);
    endtask

    initial begin
        int ca;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.req_valid  = 1'b0;
        bus.opcode     = 6'h0;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
        bus.mem_rdata  = 32'h0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;

        // sb accepted, then reset lands while in WAIT: no write may follow
        @(negedge clock);
        bus.opcode     = OP_SB;
        bus.addr       = 32'h11;
        bus.store_data = 32'hAA;
        bus.req_valid  = 1'b1;
        exp_reads++;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_idle_outputs("abort");

        //      op      addr          data           lat mis load_data     wr   waddr  wdata         wlat rd
        issue(OP_SW,  32'h10,  32'hDEADBEEF, 2, 0, 32'h0,        1, 8'd4, 32'hDEADBEEF, 1, 0);
        issue(OP_LW,  32'h10,  32'h0,        3, 0, 32'hDEADBEEF, 0, 8'd0, 32'h0,        0, 1);
        issue(OP_SW,  32'h10,  32'h80F17F02, 2, 0, 32'h0,        1, 8'd4, 32'h80F17F02, 1, 0);
        issue(OP_LB,  32'h13,  32'h0,        3, 0, 32'hFFFFFF80, 0, 8'd0, 32'h0,        0, 1);
        issue(OP_LBU, 32'h13,  32'h0,        3, 0, 32'h00000080, 0, 8'd0, 32'h0,        0, 1);
        issue(OP_LH,  32'h10,  32'h0,        3, 0, 32'h00007F02, 0, 8'd0, 32'h0,        0, 1);
        issue(OP_LHU, 32'h12,  32'h0,        3, 0, 32'h000080F1, 0, 8'd0, 32'h0,        0, 1);
        issue(OP_LH,  32'h12,  32'h0,        3, 0, 32'hFFFF80F1, 0, 8'd0, 32'h0,        0, 1);
        issue(OP_SW,  32'h10,  32'h11223344, 2, 0, 32'h0,        1, 8'd4, 32'h11223344, 1, 0);
        issue(OP_SB,  32'h11,  32'hFFFFFFAA, 4, 0, 32'h0,        1, 8'd4, 32'h1122AA44, 3, 1);
        issue(OP_SW,  32'h10,  32'h11223344, 2, 0, 32'h0,        1, 8'd4, 32'h11223344, 1, 0);
        issue(OP_SH,  32'h12,  32'h1234BEEF, 4, 0, 32'h0,        1, 8'd4, 32'hBEEF3344, 3, 1);
        issue(OP_LW,  32'h10,  32'h0,        3, 0, 32'hBEEF3344, 0, 8'd0, 32'h0,        0, 1);
        issue(OP_LW,  32'h06,  32'h0,        1, 1, 32'h0,        0, 8'd0, 32'h0,        0, 0);
        issue(OP_SH,  32'h03,  32'h5555,     1, 1, 32'h0,        0, 8'd0, 32'h0,        0, 0);
        issue(6'h00,  32'h10,  32'h0,        1, 0, 32'h0,        0, 8'd0, 32'h0,        0, 0);

        // Back-to-back: second request held while busy, accepted only after RESP
        wait_ready();
        ca = cyc;
        resp_q.push_back(resp_t'{ca + 2, 1'b0, 32'h0});
        wr_q.push_back(wr_t'{ca + 1, 8'd0, 32'hCAFEF00D});
        resp_q.push_back(resp_t'{ca + 6, 1'b0, 32'hCAFEF00D});
        exp_reads++;
        bus.opcode     = OP_SW;
        bus.addr       = 32'h400;
        bus.store_data = 32'hCAFEF00D;
        bus.req_valid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("b2b_busy",      {31'h0, bus.busy},      32'h1);
        check("b2b_req_ready", {31'h0, bus.req_ready}, 32'h0);
        bus.opcode     = OP_LW;
        bus.addr       = 32'h800;
        bus.store_data = 32'h0;
        wait_ready();
        check("b2b_accept_cycle", cyc, ca + 3);
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;

        n = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain_resp_left",  resp_q.size(), 32'h0);
        check("drain_write_left", wr_q.size(),   32'h0);
        repeat (5) @(negedge clock);
        check("mem_re_count", reads_seen, exp_reads);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
